// File: rtl/bank_pkg.sv
// bank_pkg: shared sizes and word types for the data/register bank.
package bank_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int DEPTH = 2 ** ADDR_W;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/bank_clear_seq.sv
// bank_clear_seq: walks every address once after reset so the bank can be zeroed, then flags done.
module bank_clear_seq
  import bank_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  output addr_t ptr,
  output logic  done
);
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      done <= 1'b0;
    end else if (!done) begin
      ptr <= ptr + addr_t'(1);
      done <= &ptr;
    end
  end
endmodule

// File: rtl/bank_dpram.sv
// bank_dpram: 1024x8 true dual-port write-first RAM, zero-cleared after reset; port A wins write collisions.
module bank_dpram
  import bank_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  output logic  ready,
  input  logic  wea,
  input  addr_t addra,
  input  data_t dina,
  output data_t douta,
  input  logic  web,
  input  addr_t addrb,
  input  data_t dinb,
  output data_t doutb
);
  data_t mem [DEPTH];
  addr_t ptr;
  logic  done;
  logic  same;
  bank_clear_seq u_clr (
    .clk  (clk),
    .rst  (rst),
    .ptr  (ptr),
    .done (done)
  );
  assign ready = done;
  assign same = addra == addrb;
  // A is written last so it overrides B on a shared address
  always_ff @(posedge clk) begin
    if (!rst && !done) mem[ptr] <= '0;
    else if (!rst) begin
      if (web) mem[addrb] <= dinb;
      if (wea) mem[addra] <= dina;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || !done) begin
      douta <= '0;
      doutb <= '0;
    end else begin
      douta <= wea ? dina : (web && same) ? dinb : mem[addra];
      doutb <= (wea && same) ? dina : web ? dinb : mem[addrb];
    end
  end
endmodule

// File: tb/tb_bank_dpram.sv
// tb_bank_dpram: randomized and directed checks of bank_dpram against an array model of the bank.
module tb_bank_dpram;
  import bank_pkg::*;
  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  ready;
  logic  wea = 1'b0;
  logic  web = 1'b0;
  addr_t addra = '0;
  addr_t addrb = '0;
  data_t dina = '0;
  data_t dinb = '0;
  data_t douta, doutb;
  int checks = 0;
  int failures = 0;
  data_t model [DEPTH];

  always #5 clk = ~clk;

  bank_dpram dut (
    .clk   (clk),
    .rst   (rst),
    .ready (ready),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .douta (douta),
    .web   (web),
    .addrb (addrb),
    .dinb  (dinb),
    .doutb (doutb)
  );

  // Drives one access on both ports; expected reads are the bank contents after this edge's writes
  task automatic tick(input logic wa, input addr_t aa, input data_t da,
                      input logic wb, input addr_t ab, input data_t db,
                      output data_t ea, output data_t eb);
    wea = wa; addra = aa; dina = da;
    web = wb; addrb = ab; dinb = db;
    @(posedge clk); #1;
    if (wb) model[ab] = db;
    if (wa) model[aa] = da;
    ea = model[aa];
    eb = model[ab];
    wea = 1'b0; web = 1'b0;
  endtask

  task automatic run_clear(input string tag);
    rst = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      wea = 1'b1; web = 1'b1;
      addra = addr_t'($urandom); addrb = addr_t'($urandom);
      dina = data_t'($urandom); dinb = data_t'($urandom);
      @(posedge clk); #1;
      checks++;
      if (ready !== (k == DEPTH)) begin
        failures++;
        $display("FAIL %s ready edge %0d got=%b exp=%b", tag, k, ready, k == DEPTH);
      end
      checks++;
      if (douta !== 8'h00 || doutb !== 8'h00) begin
        failures++;
        $display("FAIL %s dout edge %0d got=%h/%h exp=00/00", tag, k, douta, doutb);
      end
    end
    wea = 1'b0; web = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wea = 1'b1; web = 1'b1; dina = 8'hFF; dinb = 8'hEE;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b0 || douta !== 8'h00 || doutb !== 8'h00) begin
        failures++;
        $display("FAIL reset got ready=%b douta=%h doutb=%h exp 0/00/00", ready, douta, doutb);
      end
    end
    run_clear("clear");
  endtask

  task automatic test_zero_reads();
    data_t ea, eb;
    tick(1'b0, 10'd0, 8'h00, 1'b0, 10'd512, 8'h00, ea, eb);
    checks++;
    if (douta !== ea || doutb !== eb || ea !== 8'h00) begin
      failures++;
      $display("FAIL zero_read0_512 got=%h/%h exp=%h/%h", douta, doutb, ea, eb);
    end
    tick(1'b0, 10'd1023, 8'h00, 1'b0, 10'd1023, 8'h00, ea, eb);
    checks++;
    if (douta !== ea || doutb !== eb || ea !== 8'h00) begin
      failures++;
      $display("FAIL zero_read1023 got=%h/%h exp=%h/%h", douta, doutb, ea, eb);
    end
  endtask

  task automatic test_write_read();
    data_t ea, eb;
    tick(1'b1, 10'h010, 8'hA5, 1'b0, 10'h000, 8'h00, ea, eb);
    checks++;
    if (douta !== 8'hA5) begin
      failures++;
      $display("FAIL wr_first_a got=%h exp=a5", douta);
    end
    tick(1'b0, 10'h000, 8'h00, 1'b0, 10'h010, 8'h00, ea, eb);
    checks++;
    if (doutb !== 8'hA5 || eb !== 8'hA5) begin
      failures++;
      $display("FAIL b_reads_a got=%h exp=a5", doutb);
    end
  endtask

  task automatic test_both_write();
    data_t ea, eb;
    tick(1'b1, 10'h3FF, 8'h11, 1'b1, 10'h3FF, 8'h22, ea, eb);
    checks++;
    if (douta !== 8'h11 || doutb !== 8'h11) begin
      failures++;
      $display("FAIL both_write got=%h/%h exp=11/11", douta, doutb);
    end
    tick(1'b0, 10'h3FF, 8'h00, 1'b0, 10'h000, 8'h00, ea, eb);
    checks++;
    if (douta !== 8'h11) begin
      failures++;
      $display("FAIL both_write_readback got=%h exp=11", douta);
    end
  endtask

  task automatic test_write_read_collision();
    data_t ea, eb;
    tick(1'b1, 10'h020, 8'h5C, 1'b0, 10'h020, 8'h00, ea, eb);
    checks++;
    if (doutb !== 8'h5C || douta !== 8'h5C) begin
      failures++;
      $display("FAIL wr_rd_collision got=%h/%h exp=5c/5c", douta, doutb);
    end
    tick(1'b0, 10'h020, 8'h00, 1'b1, 10'h020, 8'h3D, ea, eb);
    checks++;
    if (douta !== 8'h3D || doutb !== 8'h3D) begin
      failures++;
      $display("FAIL rd_wr_collision got=%h/%h exp=3d/3d", douta, doutb);
    end
  endtask

  task automatic test_independent();
    data_t ea, eb;
    tick(1'b1, 10'h001, 8'h7E, 1'b1, 10'h2AA, 8'h81, ea, eb);
    checks++;
    if (douta !== 8'h7E || doutb !== 8'h81) begin
      failures++;
      $display("FAIL indep_write got=%h/%h exp=7e/81", douta, doutb);
    end
    tick(1'b0, 10'h2AA, 8'h00, 1'b0, 10'h001, 8'h00, ea, eb);
    checks++;
    if (douta !== 8'h81 || doutb !== 8'h7E) begin
      failures++;
      $display("FAIL cross_read got=%h/%h exp=81/7e", douta, doutb);
    end
  endtask

  task automatic test_random();
    data_t ea, eb;
    for (int n = 0; n < 600; n++) begin
      addr_t aa, ab;
      aa = ($urandom_range(0, 3) == 0) ? addr_t'($urandom) : addr_t'($urandom_range(0, 15));
      ab = ($urandom_range(0, 3) == 0) ? addr_t'($urandom) : addr_t'($urandom_range(0, 15));
      tick(1'($urandom), aa, data_t'($urandom), 1'($urandom), ab, data_t'($urandom), ea, eb);
      checks++;
      if (douta !== ea || doutb !== eb) begin
        failures++;
        $display("FAIL random %0d a@%h b@%h got=%h/%h exp=%h/%h", n, aa, ab, douta, doutb, ea, eb);
      end
    end
  endtask

  task automatic test_midclear_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL midclear_ready got=%b exp=0", ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b0 || douta !== 8'h00 || doutb !== 8'h00) begin
      failures++;
      $display("FAIL midclear_reset got=%b/%h/%h exp=0/00/00", ready, douta, doutb);
    end
    run_clear("midclear");
  endtask

  task automatic test_reset_after_data();
    data_t ea, eb;
    tick(1'b1, 10'h010, 8'h3C, 1'b1, 10'h3FF, 8'hC3, ea, eb);
    checks++;
    if (douta !== 8'h3C || doutb !== 8'hC3 || ready !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_write got=%h/%h ready=%b exp=3c/c3 ready=1", douta, doutb, ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b0 || douta !== 8'h00 || doutb !== 8'h00) begin
      failures++;
      $display("FAIL reset_pulse got=%b/%h/%h exp=0/00/00", ready, douta, doutb);
    end
    run_clear("reclear");
    tick(1'b0, 10'h010, 8'h00, 1'b0, 10'h3FF, 8'h00, ea, eb);
    checks++;
    if (douta !== 8'h00 || doutb !== 8'h00 || ea !== 8'h00) begin
      failures++;
      $display("FAIL reclear_read got=%h/%h exp=00/00", douta, doutb);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    test_reset();
    test_zero_reads();
    test_write_read();
    test_both_write();
    test_write_read_collision();
    test_independent();
    test_random();
    test_midclear_reset();
    test_random();
    test_reset_after_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
